// File: rtl/strl_pkg.sv
// Shared constants for the strl FIFO slice: operating modes and level-width helper.
package strl_pkg;
  localparam int MODE_REG    = 0;
  localparam int MODE_BYPASS = 1;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/strl_burst_cnt.sv
// Consecutive-transfer counter (saturating, clears on any idle cycle) and a registered
// sustained-burst flag; 1-cycle latency from sflag to count/flag, no backpressure.
module strl_burst_cnt #(
  parameter int CNT_W    = 16,
  parameter int BURST_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sflag,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             const_flag
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(BURST_TH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  // The flag is judged on the updated count so it rises together with count == TH.
  always_comb begin
    cnt_d = '0;
    if (sflag) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    flag_d = (cnt_d >= TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign burst_cnt  = cnt_q;
  assign const_flag = flag_q;
endmodule

// File: rtl/strl_fifo_slice.sv
// Circular-buffer FIFO slice: MODE 0 registered (1-cycle), MODE 1 bypasses when empty (0-cycle);
// ready_s depends only on the registered level, so backpressure never ripples combinationally.
module strl_fifo_slice
  import strl_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int MODE     = 0,
  parameter int CNT_W    = 16,
  parameter int BURST_TH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             data_s,
  input  logic                      vld_s,
  output logic                      ready_s,
  output logic [DW-1:0]             data_m,
  output logic                      vld_m,
  input  logic                      ready_m,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [CNT_W-1:0]          burst_cnt,
  output logic                      const_flag
);
  localparam int                PW      = $clog2(DEPTH);
  localparam int                LW      = lvl_w(DEPTH);
  localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);
  localparam bit                BYP     = (MODE == MODE_BYPASS);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic empty, bypass, sflag, mflag, push, pop;

  assign empty   = (level_q == '0);
  assign bypass  = BYP && empty;
  assign ready_s = (level_q != DEPTH_L);
  assign sflag   = vld_s & ready_s;
  assign vld_m   = bypass ? sflag : !empty;
  assign data_m  = bypass ? data_s : mem_q[rd_ptr_q];
  assign mflag   = vld_m & ready_m;

  // A beat that passes straight through on an empty bypass slice is never stored.
  assign push = sflag & !(bypass & mflag);
  assign pop  = mflag & !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_s;
  end

  assign level = level_q;

  strl_burst_cnt #(
    .CNT_W    (CNT_W),
    .BURST_TH (BURST_TH)
  ) u_burst (
    .clk        (clk),
    .rst        (rst),
    .sflag      (sflag),
    .burst_cnt  (burst_cnt),
    .const_flag (const_flag)
  );
endmodule

// File: tb/tb_strl_fifo_slice.sv
// Scoreboard bench: a registered slice (MODE 0, 16-bit counter) and a bypass slice (MODE 1, 3-bit counter).
module tb_strl_fifo_slice;
  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] d0_s, d0_m;
  logic        v0_s, r0_s, v0_m, r0_m, c0_f;
  logic [2:0]  l0;
  logic [15:0] b0;

  logic [31:0] d1_s, d1_m;
  logic        v1_s, r1_s, v1_m, r1_m, c1_f;
  logic [2:0]  l1;
  logic [2:0]  b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  always #5 clk = ~clk;

  strl_fifo_slice #(.DW(32), .DEPTH(4), .MODE(0), .CNT_W(16), .BURST_TH(4)) u_reg (
    .clk(clk), .rst(rst), .data_s(d0_s), .vld_s(v0_s), .ready_s(r0_s),
    .data_m(d0_m), .vld_m(v0_m), .ready_m(r0_m), .level(l0),
    .burst_cnt(b0), .const_flag(c0_f)
  );

  strl_fifo_slice #(.DW(32), .DEPTH(4), .MODE(1), .CNT_W(3), .BURST_TH(4)) u_byp (
    .clk(clk), .rst(rst), .data_s(d1_s), .vld_s(v1_s), .ready_s(r1_s),
    .data_m(d1_m), .vld_m(v1_m), .ready_m(r1_m), .level(l1),
    .burst_cnt(b1), .const_flag(c1_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every downstream handshake must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!rst && v0_m && r0_m) begin
      if (exp_q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon0_unexpected: got beat %0h, required none", d0_m);
      end else chk("mon0_data", d0_m, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && v1_m && r1_m) begin
      if (exp_q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon1_unexpected: got beat %0h, required none", d1_m);
      end else chk("mon1_data", d1_m, exp_q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d0_s = '0; v0_s = 1'b0; r0_m = 1'b0;
    d1_s = '0; v1_s = 1'b0; r1_m = 1'b0;
    tick(); tick();
    chk("rst_level0", {29'b0, l0}, 32'd0);
    chk("rst_vld0",   {31'b0, v0_m}, 32'd0);
    chk("rst_ready0", {31'b0, r0_s}, 32'd1);
    chk("rst_burst0", {16'b0, b0}, 32'd0);
    chk("rst_const0", {31'b0, c0_f}, 32'd0);
    chk("rst_ready1", {31'b0, r1_s}, 32'd1);
    rst = 1'b0;

    // Fill with ready_m low: four beats accepted, the fifth (0x55) refused.
    for (int i = 0; i < 5; i++) begin
      v0_s = 1'b1;
      d0_s = 32'(i + 1) * 32'h11;
      #1;
      chk("fill_ready", {31'b0, r0_s}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q0.push_back(d0_s);
      tick();
      chk("fill_level", {29'b0, l0}, (i < 4) ? 32'(i + 1) : 32'd4);
    end
    v0_s = 1'b0;

    // Drain: 0x11..0x44 checked by the monitor, level counts down.
    r0_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_level", {29'b0, l0}, 32'(3 - i));
      chk("drain_ready", {31'b0, r0_s}, 32'd1);
    end
    chk("drain_vld_off", {31'b0, v0_m}, 32'd0);

    // Five-beat burst then one idle cycle.
    for (int i = 0; i < 5; i++) begin
      v0_s = 1'b1;
      d0_s = 32'hC0 + 32'(i);
      exp_q0.push_back(d0_s);
      tick();
      chk("burst_cnt", {16'b0, b0}, 32'(i + 1));
      chk("burst_const", {31'b0, c0_f}, (i >= 3) ? 32'd1 : 32'd0);
    end
    v0_s = 1'b0;
    tick();
    chk("burst_idle_cnt", {16'b0, b0}, 32'd0);
    chk("burst_idle_const", {31'b0, c0_f}, 32'd0);
    chk("burst_level", {29'b0, l0}, 32'd0);
    tick();
    chk("burst_drained", 32'(exp_q0.size()), 32'd0);

    // Reset with three beats stored: nothing must come out afterwards.
    r0_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v0_s = 1'b1;
      d0_s = 32'hD1 + 32'(i);
      tick();
    end
    v0_s = 1'b0;
    chk("pre_rst_level", {29'b0, l0}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_level", {29'b0, l0}, 32'd0);
    chk("post_rst_vld", {31'b0, v0_m}, 32'd0);
    chk("post_rst_ready", {31'b0, r0_s}, 32'd1);
    r0_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_vld", {31'b0, v0_m}, 32'd0);
    end
    r0_m = 1'b0;

    // Bypass slice: empty with ready_m high passes 0xAB through in the same cycle.
    r1_m = 1'b1;
    v1_s = 1'b1;
    d1_s = 32'hAB;
    exp_q1.push_back(32'hAB);
    #1;
    chk("byp_vld", {31'b0, v1_m}, 32'd1);
    chk("byp_data", d1_m, 32'hAB);
    tick();
    chk("byp_level", {29'b0, l1}, 32'd0);
    v1_s = 1'b0;
    tick();
    chk("byp_idle_cnt", {29'b0, b1}, 32'd0);

    // Ten continuous transfers on the 3-bit counter: saturates at 7.
    for (int i = 0; i < 10; i++) begin
      v1_s = 1'b1;
      d1_s = 32'h60 + 32'(i);
      exp_q1.push_back(d1_s);
      tick();
      chk("sat_cnt", {29'b0, b1}, (i < 7) ? 32'(i + 1) : 32'd7);
      chk("sat_level", {29'b0, l1}, 32'd0);
    end
    v1_s = 1'b0;
    tick();
    chk("sat_clear", {29'b0, b1}, 32'd0);

    // Bypass slice with stalled output behaves as a registered FIFO and holds its head.
    r1_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v1_s = 1'b1;
      d1_s = 32'h71 + 32'(i);
      exp_q1.push_back(d1_s);
      tick();
    end
    v1_s = 1'b0;
    d1_s = 32'hFF;
    #1;
    chk("stall_level", {29'b0, l1}, 32'd2);
    chk("stall_vld", {31'b0, v1_m}, 32'd1);
    chk("stall_head", d1_m, 32'h71);
    tick();
    chk("stall_hold", d1_m, 32'h71);
    r1_m = 1'b1;
    tick(); tick();
    chk("stall_drained_level", {29'b0, l1}, 32'd0);
    chk("stall_drained_q", 32'(exp_q1.size()), 32'd0);
    r1_m = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
